// File: rtl/key_pkg.sv
// Shared types and sizing helpers for the key debounce block.
// Latency: none (declarations only).
// Backpressure: none.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_FILT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_FILT = 2'd3
  } key_state_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input bit.
// Latency: 2 clk edges from input change to q_o.
// Backpressure: none; samples every cycle. RST_VAL sets the reset level.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rstn,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Shift the raw input through two flops to settle metastability.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/key_debounce.sv
// Key debouncer: sync, stability filter, clean level plus press/release pulses.
// Latency: DEBOUNCE_CYCLES+3 edges from key_in settling to key_level/pulse.
// Backpressure: none. Optional long-press pulse under KEY_DEBOUNCE_LONG_PRESS_EN.
module key_debounce
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned LONG_CYCLES     = 50_000_000,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic rstn,
  input  logic key_in,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_long
);

  localparam int unsigned DEB_W   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic        REL_LVL = ACTIVE_LOW;

  // Illegal configurations stop elaboration rather than build a broken filter.
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("key_debounce: DEBOUNCE_CYCLES must be >= 2");
  end
  if (LONG_CYCLES < 2) begin : g_bad_long
    $error("key_debounce: LONG_CYCLES must be >= 2");
  end

  logic key_sync;
  logic k;

  // Synchroniser idles at the released level so reset never looks like a press.
  sync_2ff #(
    .RST_VAL (REL_LVL)
  ) u_sync (
    .clk  (clk),
    .rstn (rstn),
    .d_i  (key_in),
    .q_o  (key_sync)
  );

  // Normalised key: 1 = pressed regardless of board polarity.
  assign k = key_sync ^ REL_LVL;

  key_state_e       state_q, state_d;
  logic [DEB_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             rel_q, rel_d;

  // State, filter counter and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  // Next state: a level change is accepted only after DEBOUNCE_CYCLES stable samples;
  // any contrary sample during filtering drops back without a pulse.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (k) begin
          state_d = PRESS_FILT;
          cnt_d   = '0;
        end
      end
      PRESS_FILT: begin
        if (!k) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DEB_MAX) begin
          state_d = PRESSED;
          cnt_d   = '0;
          level_d = 1'b1;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + DEB_W'(1);
        end
      end
      PRESSED: begin
        if (!k) begin
          state_d = RELEASE_FILT;
          cnt_d   = '0;
        end
      end
      RELEASE_FILT: begin
        if (k) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == DEB_MAX) begin
          state_d = IDLE;
          cnt_d   = '0;
          level_d = 1'b0;
          rel_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + DEB_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign key_level   = level_q;
  assign key_press   = press_q;
  assign key_release = rel_q;

`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
  localparam int unsigned LONG_W = cnt_width(LONG_CYCLES);
  localparam logic [LONG_W-1:0] LONG_MAX = LONG_W'(LONG_CYCLES - 1);

  logic [LONG_W-1:0] long_cnt_q, long_cnt_d;
  logic              long_done_q, long_done_d;
  logic              long_q, long_d;

  // Long-press counter, one-shot flag and pulse register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      long_cnt_q  <= '0;
      long_done_q <= 1'b0;
      long_q      <= 1'b0;
    end else begin
      long_cnt_q  <= long_cnt_d;
      long_done_q <= long_done_d;
      long_q      <= long_d;
    end
  end

  // Count time spent pressed; fire once, then hold until the next PRESSED entry.
  always_comb begin
    long_cnt_d  = long_cnt_q;
    long_done_d = long_done_q;
    long_d      = 1'b0;
    if ((state_d == PRESSED && state_q != PRESSED) ||
        (state_d == IDLE && state_q != IDLE)) begin
      long_cnt_d  = '0;
      long_done_d = 1'b0;
    end else if ((state_q == PRESSED || state_q == RELEASE_FILT) && !long_done_q) begin
      if (long_cnt_q == LONG_MAX) begin
        long_d      = 1'b1;
        long_done_d = 1'b1;
      end else begin
        long_cnt_d = long_cnt_q + LONG_W'(1);
      end
    end
  end

  assign key_long = long_q;
`else
  assign key_long = 1'b0;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce with DEBOUNCE_CYCLES=4, LONG_CYCLES=10, ACTIVE_LOW=1.
// Per-cycle vector table plus hand-written reset sequences.
// Outputs are sampled 1 time unit after each rising edge.
module tb_key_debounce;

  logic clk;
  logic rstn;
  logic key_in;
  logic key_level;
  logic key_press;
  logic key_release;
  logic key_long;

  int checks = 0;
  int errors = 0;

  key_debounce #(
    .DEBOUNCE_CYCLES (4),
    .LONG_CYCLES     (10),
    .ACTIVE_LOW      (1'b1)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .key_in      (key_in),
    .key_level   (key_level),
    .key_press   (key_press),
    .key_release (key_release),
    .key_long    (key_long)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic key;
    logic lvl;
    logic prs;
    logic rel;
    logic lng;
    bit   chk_lng;
  } vec_t;

  vec_t vecs[$];

`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
  localparam bit LONG_CHK_DEFAULT = 1'b0;
`else
  localparam bit LONG_CHK_DEFAULT = 1'b1;
`endif

  function automatic void add(input int n, input logic key, input logic lvl,
                              input logic prs, input logic rel);
    vec_t v;
    v.key = key; v.lvl = lvl; v.prs = prs; v.rel = rel;
    v.lng = 1'b0; v.chk_lng = LONG_CHK_DEFAULT;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endfunction

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Counts edges after the caller's last edge until key_press; reports first hit and total.
  task automatic wait_press(input string name, input int exp_edge);
    int first;
    int npress;
    first  = 0;
    npress = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (key_press === 1'b1) begin
        npress++;
        if (first == 0) first = n;
      end
    end
    check_int({name, "_press_edge"}, first, exp_edge);
    check_int({name, "_press_count"}, npress, 1);
    check_bit({name, "_level"}, key_level, 1'b1);
  endtask

  initial begin
    int s2_start;
    int idx;
    logic [3:0] act;
    logic [3:0] exp;

    // S1 idle, released
    add(20, 1'b1, 1'b0, 1'b0, 1'b0);
    // S2/S5 clean press held 40 cycles
    s2_start = vecs.size();
    add(6,  1'b0, 1'b0, 1'b0, 1'b0);
    add(1,  1'b0, 1'b1, 1'b1, 1'b0);
    add(33, 1'b0, 1'b1, 1'b0, 1'b0);
`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
    for (int i = s2_start; i < s2_start + 40; i++) vecs[i].chk_lng = 1'b1;
    vecs[s2_start + 16].lng = 1'b1;
`endif
    // S4 glitch during release filter: level stays pressed
    add(2,  1'b1, 1'b1, 1'b0, 1'b0);
    add(10, 1'b0, 1'b1, 1'b0, 1'b0);
    // S4 clean release
    add(6,  1'b1, 1'b1, 1'b0, 1'b0);
    add(1,  1'b1, 1'b0, 1'b0, 1'b1);
    add(10, 1'b1, 1'b0, 1'b0, 1'b0);
    // S3 bounce x3 then settle pressed
    for (int r = 0; r < 3; r++) begin
      add(3, 1'b0, 1'b0, 1'b0, 1'b0);
      add(2, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    add(6, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1, 1'b0, 1'b1, 1'b1, 1'b0);
    add(5, 1'b0, 1'b1, 1'b0, 1'b0);
    // back to idle
    add(6, 1'b1, 1'b1, 1'b0, 1'b0);
    add(1, 1'b1, 1'b0, 1'b0, 1'b1);
    add(3, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset with key released
    rstn   = 1'b0;
    key_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_bit("rst_level",   key_level,   1'b0);
    check_bit("rst_press",   key_press,   1'b0);
    check_bit("rst_release", key_release, 1'b0);
    check_bit("rst_long",    key_long,    1'b0);
    rstn = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      key_in = vecs[i].key;
      @(posedge clk); #1;
      act = {key_level, key_press, key_release, 1'b0};
      exp = {vecs[i].lvl, vecs[i].prs, vecs[i].rel, 1'b0};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL vec[%0d] {level,press,release}: got %b%b%b expected %b%b%b",
                 i, act[3], act[2], act[1], exp[3], exp[2], exp[1]);
      end
      if (vecs[i].chk_lng) begin
        checks++;
        if (key_long !== vecs[i].lng) begin
          errors++;
          $display("FAIL vec[%0d] key_long: got %b expected %b", i, key_long, vecs[i].lng);
        end
      end
    end

    // S6: reset pulse while in press filter, key held pressed
    key_in = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    check_bit("s6_rst_level", key_level, 1'b0);
    check_bit("s6_rst_press", key_press, 1'b0);
    @(posedge clk); #1;
    rstn = 1'b1;
    wait_press("s6", 7);

    // Reset while pressed: level drops without a clock edge, latency restarts
    idx = 0;
    #3;
    rstn = 1'b0;
    #1;
    check_bit("midpress_rst_level", key_level, 1'b0);
    check_bit("midpress_rst_long",  key_long,  1'b0);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    wait_press("midpress", 7);

    key_in = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check_bit("final_level", key_level, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
